// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states, op codes, default width.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 64;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIter,
    StDone
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_counter.sv
// Iteration counter for the mul/div sequencer: clear, saturating increment, terminal-count flag.
module muldiv_iter_counter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             incr,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (incr && (count_q != CNT_W'(WIDTH))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // Terminal count: the cycle that issues the final shift.
  assign last  = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_controller.sv
// Sequencing FSM for the shared shift-add multiplier / restoring divider datapath.
module muldiv_controller
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             divisor_zero,
  input  logic             mul_lsb,
  input  logic             div_neg,
  output logic             initial_wr,
  output logic             wr,
  output logic             sh_right,
  output logic             sh_left,
  output logic             alu_sub,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [CNT_W-1:0] iter_count
);

  muldiv_state_e state_q, state_d;
  logic          op_q, op_d;
  logic          dbz_q, dbz_d;
  logic          cnt_clear, cnt_incr, cnt_last;

  muldiv_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .incr (cnt_incr),
    .count(iter_count),
    .last (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dbz_d      = dbz_q;
    cnt_clear  = 1'b0;
    cnt_incr   = 1'b0;
    initial_wr = 1'b0;
    wr         = 1'b0;
    sh_right   = 1'b0;
    sh_left    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    alu_sub    = op_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op;
          dbz_d     = op & divisor_zero;
          cnt_clear = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        initial_wr = 1'b1;
        busy       = 1'b1;
        // A zero divisor skips the iterations entirely; the flag reports the error.
        state_d    = ((op_q == OP_DIV) && dbz_q) ? StDone : StIter;
      end
      StIter: begin
        busy     = 1'b1;
        cnt_incr = 1'b1;
        if (op_q == OP_DIV) begin
          sh_left = 1'b1;
          wr      = ~div_neg;
        end else begin
          sh_right = 1'b1;
          wr       = mul_lsb;
        end
        if (cnt_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OP_MUL;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dbz_q   <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// Directed bench: controller driving a behavioural 128-bit result register and 65-bit add/sub.
module tb_muldiv_controller;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic             divisor_zero = 1'b0;
  logic             mul_lsb;
  logic             div_neg;
  logic             initial_wr, wr, sh_right, sh_left, alu_sub, busy, done, div_by_zero;
  logic [CNT_W-1:0] iter_count;

  logic [63:0] operand_a = '0;  // multiplier / dividend
  logic [63:0] operand_b = '0;  // multiplicand / divisor
  logic [63:0] res_hi = '0;
  logic [63:0] res_lo = '0;
  logic [64:0] sum;
  logic [65:0] trial;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  muldiv_controller #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .divisor_zero(divisor_zero),
    .mul_lsb     (mul_lsb),
    .div_neg     (div_neg),
    .initial_wr  (initial_wr),
    .wr          (wr),
    .sh_right    (sh_right),
    .sh_left     (sh_left),
    .alu_sub     (alu_sub),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .iter_count  (iter_count)
  );

  // Behavioural datapath: shift-add multiply (right) and restoring divide (left).
  assign sum     = {1'b0, res_hi} + {1'b0, operand_b};
  assign trial   = {1'b0, res_hi, res_lo[63]} - {2'b00, operand_b};
  assign mul_lsb = res_lo[0];
  assign div_neg = trial[65];

  always @(posedge clk) begin
    if (initial_wr) begin
      res_hi <= '0;
      res_lo <= operand_a;
    end else if (sh_right) begin
      if (wr) begin
        res_hi <= sum[64:1];
        res_lo <= {sum[0], res_lo[63:1]};
      end else begin
        res_hi <= {1'b0, res_hi[63:1]};
        res_lo <= {res_hi[0], res_lo[63:1]};
      end
    end else if (sh_left) begin
      if (wr) begin
        res_hi <= trial[63:0];
        res_lo <= {res_lo[62:0], 1'b1};
      end else begin
        res_hi <= {res_hi[62:0], res_lo[63]};
        res_lo <= {res_lo[62:0], 1'b0};
      end
    end
  end

  // Per-cycle observation statistics, filled by observe().
  int iw_cyc, n_shr, n_shl, first_sh, last_sh, done_cyc, done2_cyc, n_done, bad;

  task automatic launch(input logic o, input logic dz, input logic [63:0] a,
                        input logic [63:0] b, input bit hold);
    @(negedge clk);
    operand_a    = a;
    operand_b    = b;
    op           = o;
    divisor_zero = dz;
    start        = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Watch ncyc cycles after start was sampled; optionally pulse start at cycles p1 and p2.
  task automatic observe(input int ncyc, input int p1, input int p2);
    iw_cyc = -1; n_shr = 0; n_shl = 0; first_sh = -1; last_sh = -1;
    done_cyc = -1; done2_cyc = -1; n_done = 0; bad = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (initial_wr && iw_cyc < 0) iw_cyc = c;
      if (sh_right) n_shr++;
      if (sh_left) n_shl++;
      if (sh_right || sh_left) begin
        if (first_sh < 0) first_sh = c;
        last_sh = c;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
        else if (done2_cyc < 0) done2_cyc = c;
      end
      if ((sh_right && sh_left) || (initial_wr && (sh_right || sh_left))) bad++;
      if (c == p1 || c == p2) begin
        start = 1'b1;
        op    = 1'b1;
      end else if (c == p1 + 1 || c == p2 + 1) begin
        start = 1'b0;
        op    = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({initial_wr, wr, sh_right, sh_left, alu_sub, busy, done, div_by_zero} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {initial_wr, wr, sh_right, sh_left, alu_sub, busy, done, div_by_zero});
    end
    compared++;
    if (iter_count !== 7'd0) begin
      mismatched++; $display("FAIL reset_iter_count: got %0d expected 0", iter_count);
    end
  endtask

  task automatic test_mul;
    launch(1'b0, 1'b0, 64'd7, 64'd6, 1'b0);
    observe(70, -5, -5);
    compared++;
    if (iw_cyc !== 1) begin mismatched++; $display("FAIL mul_initial_wr_cycle: got %0d expected 1", iw_cyc); end
    compared++;
    if (n_shr !== 64) begin mismatched++; $display("FAIL mul_sh_right_count: got %0d expected 64", n_shr); end
    compared++;
    if (n_shl !== 0) begin mismatched++; $display("FAIL mul_sh_left_count: got %0d expected 0", n_shl); end
    compared++;
    if (first_sh !== 2 || last_sh !== 65) begin
      mismatched++; $display("FAIL mul_shift_window: got %0d..%0d expected 2..65", first_sh, last_sh);
    end
    compared++;
    if (done_cyc !== 66 || n_done !== 1) begin
      mismatched++; $display("FAIL mul_done: got cycle %0d count %0d expected cycle 66 count 1", done_cyc, n_done);
    end
    compared++;
    if (res_lo !== 64'd42 || res_hi !== 64'd0) begin
      mismatched++; $display("FAIL mul_result: got %h_%h expected 0_2a", res_hi, res_lo);
    end
    compared++;
    if (iter_count !== 7'd64) begin mismatched++; $display("FAIL mul_iter_count: got %0d expected 64", iter_count); end
    compared++;
    if (alu_sub !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
      mismatched++; $display("FAIL mul_idle_flags: got sub=%b busy=%b dbz=%b expected 0 0 0", alu_sub, busy, div_by_zero);
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL mul_strobe_overlap: got %0d expected 0", bad); end
  endtask

  task automatic test_div;
    launch(1'b1, 1'b0, 64'd100, 64'd7, 1'b0);
    observe(70, -5, -5);
    compared++;
    if (n_shl !== 64 || n_shr !== 0) begin
      mismatched++; $display("FAIL div_shift_counts: got left=%0d right=%0d expected 64 0", n_shl, n_shr);
    end
    compared++;
    if (done_cyc !== 66) begin mismatched++; $display("FAIL div_done_cycle: got %0d expected 66", done_cyc); end
    compared++;
    if (res_lo !== 64'd14) begin mismatched++; $display("FAIL div_quotient: got %0d expected 14", res_lo); end
    compared++;
    if (res_hi !== 64'd2) begin mismatched++; $display("FAIL div_remainder: got %0d expected 2", res_hi); end
    compared++;
    if (alu_sub !== 1'b1) begin mismatched++; $display("FAIL div_alu_sub: got %b expected 1", alu_sub); end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL div_strobe_overlap: got %0d expected 0", bad); end
  endtask

  task automatic test_div_zero;
    launch(1'b1, 1'b1, 64'd5, 64'd0, 1'b0);
    divisor_zero = 1'b0;
    observe(10, -5, -5);
    compared++;
    if (iw_cyc !== 1 || done_cyc !== 2) begin
      mismatched++; $display("FAIL dz_timing: got load %0d done %0d expected 1 2", iw_cyc, done_cyc);
    end
    compared++;
    if (n_shl + n_shr !== 0) begin mismatched++; $display("FAIL dz_shifts: got %0d expected 0", n_shl + n_shr); end
    compared++;
    if (div_by_zero !== 1'b1) begin mismatched++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
    compared++;
    if (iter_count !== 7'd0) begin mismatched++; $display("FAIL dz_iter_count: got %0d expected 0", iter_count); end
    launch(1'b0, 1'b0, 64'd3, 64'd5, 1'b0);
    observe(70, -5, -5);
    compared++;
    if (div_by_zero !== 1'b0) begin mismatched++; $display("FAIL dz_flag_clear: got %b expected 0", div_by_zero); end
    compared++;
    if (res_lo !== 64'd15) begin mismatched++; $display("FAIL dz_next_mul: got %0d expected 15", res_lo); end
  endtask

  task automatic test_start_ignored;
    launch(1'b0, 1'b0, 64'd9, 64'd9, 1'b0);
    observe(140, 10, 40);
    compared++;
    if (n_done !== 1) begin mismatched++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
    compared++;
    if (iter_count !== 7'd64) begin mismatched++; $display("FAIL ignore_iter_count: got %0d expected 64", iter_count); end
    compared++;
    if (res_lo !== 64'd81 || n_shl !== 0) begin
      mismatched++; $display("FAIL ignore_result: got %0d left=%0d expected 81 0", res_lo, n_shl);
    end
  endtask

  task automatic test_reset_mid;
    int waited;
    launch(1'b0, 1'b0, 64'd11, 64'd13, 1'b0);
    waited = 0;
    while (iter_count != 7'd30 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    compared++;
    if (iter_count !== 7'd30) begin mismatched++; $display("FAIL mid_reach_30: got %0d expected 30", iter_count); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({initial_wr, wr, sh_right, sh_left, alu_sub, busy, done, div_by_zero} !== 8'h00
        || iter_count !== 7'd0) begin
      mismatched++;
      $display("FAIL mid_reset_outputs: got %b cnt %0d expected 00000000 cnt 0",
               {initial_wr, wr, sh_right, sh_left, alu_sub, busy, done, div_by_zero}, iter_count);
    end
    launch(1'b0, 1'b0, 64'hFFFF_FFFF, 64'd2, 1'b0);
    observe(70, -5, -5);
    compared++;
    if (done_cyc !== 66) begin mismatched++; $display("FAIL mid_next_done: got %0d expected 66", done_cyc); end
    compared++;
    if (res_lo !== 64'h1_FFFF_FFFE || res_hi !== 64'd0) begin
      mismatched++; $display("FAIL mid_next_result: got %h_%h expected 0_1fffffffe", res_hi, res_lo);
    end
  endtask

  task automatic test_back_to_back;
    launch(1'b0, 1'b0, 64'd3, 64'd4, 1'b1);
    observe(140, -5, -5);
    start = 1'b0;
    compared++;
    if (done_cyc !== 66) begin mismatched++; $display("FAIL b2b_first_done: got %0d expected 66", done_cyc); end
    compared++;
    if (done2_cyc - done_cyc !== 67) begin
      mismatched++; $display("FAIL b2b_done_spacing: got %0d expected 67", done2_cyc - done_cyc);
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL b2b_strobe_overlap: got %0d expected 0", bad); end
    observe(70, -5, -5);
    compared++;
    if (busy !== 1'b0 || res_lo !== 64'd12) begin
      mismatched++; $display("FAIL b2b_settle: got busy=%b result %0d expected 0 12", busy, res_lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
